// File: rtl/int_pe_psum_drain.sv
// Partial-sum drain for the bottom of a systolic int_pe column: K-tile accumulation plus a small output FIFO.
// Define INT_PE_DRAIN_SAT_EN to make every add saturate (and flag ovf_err_out) instead of wrapping.
module int_pe_psum_drain #(
  parameter int ADD_BIT_WIDTH = 24,
  parameter int ACC_WIDTH     = 32,
  parameter int DEPTH         = 8,
  parameter int TILE_W        = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_in,
  input  logic [TILE_W-1:0]        cfg_num_tiles,
  input  logic                     psum_valid_in,
  input  logic [ADD_BIT_WIDTH-1:0] psum_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_WIDTH-1:0]     out_data,
  output logic                     busy_out,
  output logic                     ovf_err_out
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Returns {overflow, sum}; overflow can only be set in the saturating build.
  function automatic logic [ACC_WIDTH:0] add_acc(input logic signed [ACC_WIDTH-1:0] a,
                                                 input logic signed [ACC_WIDTH-1:0] b);
    logic [ACC_WIDTH:0] s;
    s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
`ifdef INT_PE_DRAIN_SAT_EN
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
      return {1'b1, s[ACC_WIDTH], {(ACC_WIDTH-1){~s[ACC_WIDTH]}}};
    end
`endif
    return {1'b0, s[ACC_WIDTH-1:0]};
  endfunction

  logic [1:0]                  state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [TILE_W-1:0]           pass_q, pass_d;
  logic [TILE_W-1:0]           passes_q, passes_d;
  logic                        ovf_q, ovf_d;
  logic signed [ACC_WIDTH-1:0] acc_q [DEPTH];
  logic [ACC_WIDTH-1:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]            cnt_q, cnt_d, cnt_after_pop;
  logic [ACC_WIDTH-1:0]        head_q, head_d;

  logic signed [ACC_WIDTH-1:0] x;
  logic [ACC_WIDTH:0]          sum;
  logic                        last_pass;
  logic                        acc_we;
  logic signed [ACC_WIDTH-1:0] acc_wdata;
  logic                        push, push_ok, pop;
  logic [ACC_WIDTH-1:0]        push_data;

  assign x = ACC_WIDTH'(signed'(psum_in));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    passes_d  = passes_q;
    ovf_d     = ovf_q;
    acc_we    = 1'b0;
    acc_wdata = x;
    push      = 1'b0;
    push_data = x;
    last_pass = (pass_q == passes_q - 1'b1);
    sum       = add_acc(acc_q[idx_q], x);
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          state_d  = S_ACCUM;
          passes_d = (cfg_num_tiles == '0) ? TILE_W'(1) : cfg_num_tiles;
          idx_d    = '0;
          pass_d   = '0;
          ovf_d    = 1'b0;
        end
      end
      S_ACCUM: begin
        if (psum_valid_in) begin
          if (last_pass) begin
            push = 1'b1;
            if (passes_q != TILE_W'(1)) begin
              push_data = sum[ACC_WIDTH-1:0];
              ovf_d     = ovf_q | sum[ACC_WIDTH];
            end
          end else begin
            // The first pass overwrites, so stale entries from an earlier job never leak in.
            acc_we = 1'b1;
            if (pass_q != '0) begin
              acc_wdata = sum[ACC_WIDTH-1:0];
              ovf_d     = ovf_q | sum[ACC_WIDTH];
            end
          end
          if (idx_q == IDX_W'(DEPTH - 1)) begin
            idx_d = '0;
            if (last_pass) state_d = S_DONE;
            else           pass_d  = pass_q + 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    pop     = (cnt_q != '0) && out_ready;
    push_ok = push && ((cnt_q != CNT_W'(FIFO_DEPTH)) || pop);
    if (push && !push_ok) ovf_d = 1'b1;

    // Head register tracks the oldest surviving entry, or the new push when the FIFO would otherwise be empty.
    cnt_after_pop = cnt_q - CNT_W'(pop);
    cnt_d         = cnt_after_pop + CNT_W'(push_ok);
    head_d        = head_q;
    if (cnt_after_pop != '0) head_d = mem_q[rd_ptr_q + PTR_W'(pop)];
    else if (push_ok)        head_d = push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      pass_q   <= '0;
      passes_q <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
      for (int i = 0; i < DEPTH; i++) acc_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pass_q   <= pass_d;
      passes_q <= passes_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (acc_we)  acc_q[idx_q] <= acc_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign out_valid   = (cnt_q != '0);
  assign out_data    = head_q;
  assign busy_out    = (state_q != S_IDLE);
  assign ovf_err_out = ovf_q;

endmodule

// File: tb/tb_int_pe_psum_drain.sv
// Bench for int_pe_psum_drain (ACC_WIDTH=24 so wrap/saturation is reachable); reference model of jobs and FIFO.
module tb_int_pe_psum_drain;
  localparam int AW = 24;
  localparam int DEPTH = 8;
  localparam int FD = 4;
  localparam longint MAXV = (longint'(1) << (AW - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (AW - 1));
  localparam longint MASK = (longint'(1) << AW) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start_in = 1'b0;
  logic [3:0]        cfg = 4'd0;
  logic              psum_valid_in = 1'b0;
  logic signed [23:0] psum_in = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [AW-1:0]     out_data;
  logic              busy_out;
  logic              ovf_err_out;

  int n_cmp = 0;
  int n_bad = 0;
  bit rnd_ready = 1'b0;

  int            m_phase = 0;
  int            m_passes = 1;
  int            m_n = 0;
  longint        m_acc [DEPTH];
  logic [AW-1:0] m_q [$];
  logic [AW-1:0] m_hold = '0;
  bit            m_ovf = 1'b0;
  logic [AW-1:0] got [$];

  int_pe_psum_drain #(.ADD_BIT_WIDTH(24), .ACC_WIDTH(AW), .DEPTH(DEPTH), .TILE_W(4), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .cfg_num_tiles(cfg),
    .psum_valid_in(psum_valid_in), .psum_in(psum_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy_out(busy_out), .ovf_err_out(ovf_err_out));

  always #5 clk = ~clk;

  function automatic longint addm(input longint a, input longint b, inout bit ovf);
    longint s;
    s = a + b;
`ifdef INT_PE_DRAIN_SAT_EN
    if (s > MAXV) begin s = MAXV; ovf = 1'b1; end
    else if (s < MINV) begin s = MINV; ovf = 1'b1; end
`else
    s = s & MASK;
    if (s > MAXV) s = s - (MASK + 1);
`endif
    return s;
  endfunction

  task automatic model_step();
    bit     pop, have_push;
    longint xv, r;
    int     idx, pass;
    if (!rst) begin
      m_phase = 0; m_n = 0; m_passes = 1; m_ovf = 1'b0; m_hold = '0;
      m_q.delete();
      for (int i = 0; i < DEPTH; i++) m_acc[i] = 0;
      return;
    end
    if (out_valid && out_ready) got.push_back(out_data);
    pop = (m_q.size() > 0) && out_ready;
    have_push = 1'b0;
    r = 0;
    case (m_phase)
      0: if (start_in) begin
           m_passes = (cfg == 0) ? 1 : int'(cfg);
           m_n = 0; m_ovf = 1'b0; m_phase = 1;
         end
      1: if (psum_valid_in) begin
           idx = m_n % DEPTH;
           pass = m_n / DEPTH;
           xv = longint'(psum_in);
           if (pass == m_passes - 1) begin
             have_push = 1'b1;
             r = (m_passes == 1) ? xv : addm(m_acc[idx], xv, m_ovf);
           end else if (pass == 0) m_acc[idx] = xv;
           else m_acc[idx] = addm(m_acc[idx], xv, m_ovf);
           m_n++;
           if (m_n == DEPTH * m_passes) m_phase = 2;
         end
      default: m_phase = 0;
    endcase
    if (pop) void'(m_q.pop_front());
    if (have_push) begin
      if (m_q.size() < FD) m_q.push_back(r[AW-1:0]);
      else m_ovf = 1'b1;
    end
    if (m_q.size() > 0) m_hold = m_q[0];
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    model_step();
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    check("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
    check("out_data", 64'(out_data), 64'(m_hold));
    check("busy_out", 64'(busy_out), 64'(m_phase != 0));
    check("ovf_err_out", 64'(ovf_err_out), 64'(m_ovf));
  end

  always @(negedge clk) if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);

  task automatic start_job(input int cfg_v);
    @(negedge clk); start_in = 1'b1; cfg = 4'(cfg_v); psum_valid_in = 1'b0;
    @(negedge clk); start_in = 1'b0;
  endtask

  task automatic send(input logic signed [23:0] v, input int gap);
    for (int g = 0; g < gap; g++) begin @(negedge clk); psum_valid_in = 1'b0; end
    @(negedge clk); psum_valid_in = 1'b1; psum_in = v;
  endtask

  task automatic end_psums(input bit stray);
    @(negedge clk); start_in = 1'b0; psum_valid_in = stray; psum_in = 24'($urandom);
    @(negedge clk); psum_valid_in = 1'b0;
  endtask

  task automatic wait_quiet(input bit drain);
    int k;
    k = 0;
    while (!(m_phase == 0 && (!drain || m_q.size() == 0))) begin
      @(negedge clk);
      k++;
      if (k > 300) begin
        n_cmp++; n_bad++;
        $display("FAIL wait_quiet: timeout after %0d cycles, required idle", k);
        return;
      end
    end
  endtask

  task automatic check_got(input string name, input int n, input logic [AW-1:0] first, input logic [AW-1:0] inc);
    logic [AW-1:0] e;
    check({name, "_count"}, 64'(got.size()), 64'(n));
    e = first;
    for (int i = 0; i < n && i < got.size(); i++) begin
      check(name, 64'(got[i]), 64'(e));
      e = e + inc;
    end
  endtask

  initial begin
    int cv, np;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_busy", 64'(busy_out), 64'd0);
    @(negedge clk); rst = 1'b1;

    // single pass: results 1..8, head visible one cycle after first psum
    got.delete(); out_ready = 1'b1;
    start_job(1);
    send(24'sd1, 0);
    @(posedge clk); #1;
    check("t1_first_valid", 64'(out_valid), 64'd1);
    check("t1_first_data", 64'(out_data), 64'd1);
    for (int i = 2; i <= 8; i++) send(24'(i), 0);
    end_psums(1'b0);
    wait_quiet(1);
    check_got("t1_data", 8, 24'd1, 24'd1);

    // three passes of -5 with gaps
    got.delete();
    start_job(3);
    for (int i = 0; i < 24; i++) send(-24'sd5, $urandom_range(0, 2));
    end_psums(1'b0);
    wait_quiet(1);
    check_got("t2_data", 8, 24'hFFFFF1, 24'd0);

    // backpressure overflow drops results 5..8
    got.delete(); out_ready = 1'b0;
    start_job(1);
    for (int i = 1; i <= 8; i++) send(24'(i), 0);
    end_psums(1'b0);
    wait_quiet(0);
    check("t3_ovf", 64'(ovf_err_out), 64'd1);
    out_ready = 1'b1;
    wait_quiet(1);
    check_got("t3_data", 4, 24'd1, 24'd1);

    // push into full FIFO while popping is accepted
    got.delete(); out_ready = 1'b0;
    start_job(1);
    for (int i = 10; i <= 13; i++) send(24'(i), 0);
    @(negedge clk); psum_valid_in = 1'b1; psum_in = 24'sd14; out_ready = 1'b1;
    for (int i = 15; i <= 17; i++) send(24'(i), 0);
    end_psums(1'b0);
    wait_quiet(1);
    check("t4_ovf", 64'(ovf_err_out), 64'd0);
    check_got("t4_data", 8, 24'd10, 24'd1);

    // two passes of max positive
    got.delete();
    start_job(2);
    for (int i = 0; i < 16; i++) send(24'sh7FFFFF, 0);
    end_psums(1'b0);
    wait_quiet(1);
`ifdef INT_PE_DRAIN_SAT_EN
    check_got("t5_data", 8, 24'h7FFFFF, 24'd0);
    check("t5_ovf", 64'(ovf_err_out), 64'd1);
`else
    check_got("t5_data", 8, 24'hFFFFFE, 24'd0);
    check("t5_ovf", 64'(ovf_err_out), 64'd0);
`endif

    // reset mid-job, then a fresh job
    out_ready = 1'b0;
    start_job(2);
    for (int i = 0; i < 5; i++) send(24'(50 + i), 0);
    @(negedge clk); rst = 1'b0; psum_valid_in = 1'b0;
    @(posedge clk); #1;
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_data", 64'(out_data), 64'd0);
    check("t6_rst_busy", 64'(busy_out), 64'd0);
    check("t6_rst_ovf", 64'(ovf_err_out), 64'd0);
    @(negedge clk); rst = 1'b1; got.delete(); out_ready = 1'b1;
    start_job(1);
    for (int i = 100; i <= 107; i++) send(24'(i), 0);
    end_psums(1'b0);
    wait_quiet(1);
    check_got("t6_data", 8, 24'd100, 24'd1);

    // randomized jobs with random readiness, stray starts and stray valids
    rnd_ready = 1'b1;
    for (int j = 0; j < 30; j++) begin
      cv = $urandom_range(0, 4);
      np = DEPTH * ((cv == 0) ? 1 : cv);
      start_job(cv);
      for (int i = 0; i < np; i++) begin
        if ($urandom_range(0, 1) == 0) send(24'($urandom), $urandom_range(0, 2));
        else send(24'($signed($urandom_range(0, 200)) - 100), $urandom_range(0, 2));
        start_in = ($urandom_range(0, 7) == 0);
      end
      end_psums(1'b1);
      wait_quiet(0);
    end
    rnd_ready = 1'b0;
    @(negedge clk); out_ready = 1'b1;
    wait_quiet(1);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
